// File: rtl/idecode_stage.sv
// -----------------------------------------------------------------------------
// idecode_stage
//   Decode stage of the mini RISC-V CPU. Holds the 32x32 integer register file,
//   decodes the fetched instruction into a control bundle and a sign-extended
//   immediate, and registers everything into the decode/execute pipeline
//   register (one cycle of latency).
//
// Ports
//   i_clk          system clock, all state updates on posedge
//   i_rst          asynchronous reset, active-low
//   i_inst         32-bit instruction from fetch
//   i_inst_valid   i_inst holds a real instruction
//   i_stall        hold pipeline register contents
//   i_flush        replace next pipeline contents with a bubble
//   i_wb_en        writeback enable
//   i_wb_addr      writeback destination register
//   i_wb_data      writeback data
//   o_out_valid    pipeline register holds a valid instruction
//   o_rs1_data     source operand 1 value
//   o_rs2_data     source operand 2 value
//   o_imm32        sign-extended immediate (byte offset for branches/jumps)
//   o_rd           destination register index (inst[11:7])
//   o_funct3       inst[14:12]
//   o_funct7b5     inst[30]
//   o_alu_op       00 add, 01 branch compare, 10 R-type, 11 I-ALU
//   o_alu_src .. o_reg_write   control bundle
//   o_illegal      unrecognised opcode
// -----------------------------------------------------------------------------
module idecode_stage #(
  parameter logic [31:0] SP_INIT = 32'h0000_7FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst,
  input  logic        i_inst_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_wb_en,
  input  logic [4:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_out_valid,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  output logic [31:0] o_imm32,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_funct3,
  output logic        o_funct7b5,
  output logic [1:0]  o_alu_op,
  output logic        o_alu_src,
  output logic        o_branch,
  output logic        o_jal,
  output logic        o_jalr,
  output logic        o_lui,
  output logic        o_auipc,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic        o_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Instruction fields
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [4:0] w_rs1_idx;
  logic [4:0] w_rs2_idx;
  logic       w_wb_active;

  assign w_opcode    = i_inst[6:0];
  assign w_rd        = i_inst[11:7];
  assign w_rs1_idx   = i_inst[19:15];
  assign w_rs2_idx   = i_inst[24:20];
  assign w_wb_active = i_wb_en && (i_wb_addr != 5'd0);

  // ---------------------------------------------------------------------------
  // Register file. Entry 0 is never written and is masked on read as well.
  // Reset is asynchronous, so the array lives in flops rather than block RAM.
  // ---------------------------------------------------------------------------
  logic [31:0] r_regs [0:31];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[2] <= SP_INIT;
      r_regs[3] <= GP_INIT;
    end else if (w_wb_active) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Combinational reads with write-through bypass so a value being written
  // back this cycle is seen by the instruction decoded in the same cycle.
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;

  always_comb begin
    w_rs1_val = r_regs[w_rs1_idx];
    if (w_rs1_idx == 5'd0) begin
      w_rs1_val = '0;
    end else if (w_wb_active && (i_wb_addr == w_rs1_idx)) begin
      w_rs1_val = i_wb_data;
    end
  end

  always_comb begin
    w_rs2_val = r_regs[w_rs2_idx];
    if (w_rs2_idx == 5'd0) begin
      w_rs2_val = '0;
    end else if (w_wb_active && (i_wb_addr == w_rs2_idx)) begin
      w_rs2_val = i_wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Immediate formats, all sign-extended from inst[31]
  // ---------------------------------------------------------------------------
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u = {i_inst[31:12], 12'b0};
  assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  logic [31:0] w_imm;
  logic [1:0]  w_alu_op;
  logic        w_alu_src;
  logic        w_branch;
  logic        w_jal;
  logic        w_jalr;
  logic        w_lui;
  logic        w_auipc;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_mem_to_reg;
  logic        w_reg_write;
  logic        w_illegal;

  always_comb begin
    w_imm        = '0;
    w_alu_op     = 2'b00;
    w_alu_src    = 1'b0;
    w_branch     = 1'b0;
    w_jal        = 1'b0;
    w_jalr       = 1'b0;
    w_lui        = 1'b0;
    w_auipc      = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
      end
      OP_IALU: begin
        w_imm       = w_imm_i;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = 2'b11;
      end
      OP_LOAD: begin
        w_imm        = w_imm_i;
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        w_imm       = w_imm_s;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_BRANCH: begin
        w_imm    = w_imm_b;
        w_branch = 1'b1;
        w_alu_op = 2'b01;
      end
      OP_JAL: begin
        w_imm       = w_imm_j;
        w_jal       = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_JALR: begin
        w_imm       = w_imm_i;
        w_jalr      = 1'b1;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      OP_LUI: begin
        w_imm       = w_imm_u;
        w_lui       = 1'b1;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      OP_AUIPC: begin
        w_imm       = w_imm_u;
        w_auipc     = 1'b1;
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
    // A write to x0 is architecturally a no-op; drop it here so later stages
    // never need to special-case rd == 0.
    if (w_rd == 5'd0) begin
      w_reg_write = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode/execute pipeline register. Priority: flush > stall > load.
  // A flush clears validity and controls only; data fields are left as-is
  // since nothing downstream consumes them without out_valid.
  // ---------------------------------------------------------------------------
  logic        r_out_valid;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_imm32;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic        r_funct7b5;
  logic [1:0]  r_alu_op;
  logic        r_alu_src;
  logic        r_branch;
  logic        r_jal;
  logic        r_jalr;
  logic        r_lui;
  logic        r_auipc;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_mem_to_reg;
  logic        r_reg_write;
  logic        r_illegal;

  // Controls are gated by inst_valid so a fetch bubble cannot issue side effects.
  logic w_v;
  assign w_v = i_inst_valid;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_out_valid  <= 1'b0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm32      <= '0;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_funct7b5   <= 1'b0;
      r_alu_op     <= 2'b00;
      r_alu_src    <= 1'b0;
      r_branch     <= 1'b0;
      r_jal        <= 1'b0;
      r_jalr       <= 1'b0;
      r_lui        <= 1'b0;
      r_auipc      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_alu_op     <= 2'b00;
      r_alu_src    <= 1'b0;
      r_branch     <= 1'b0;
      r_jal        <= 1'b0;
      r_jalr       <= 1'b0;
      r_lui        <= 1'b0;
      r_auipc      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (!i_stall) begin
      r_out_valid  <= w_v;
      r_rs1_data   <= w_rs1_val;
      r_rs2_data   <= w_rs2_val;
      r_imm32      <= w_imm;
      r_rd         <= w_rd;
      r_funct3     <= i_inst[14:12];
      r_funct7b5   <= i_inst[30];
      r_alu_op     <= w_v ? w_alu_op : 2'b00;
      r_alu_src    <= w_v & w_alu_src;
      r_branch     <= w_v & w_branch;
      r_jal        <= w_v & w_jal;
      r_jalr       <= w_v & w_jalr;
      r_lui        <= w_v & w_lui;
      r_auipc      <= w_v & w_auipc;
      r_mem_read   <= w_v & w_mem_read;
      r_mem_write  <= w_v & w_mem_write;
      r_mem_to_reg <= w_v & w_mem_to_reg;
      r_reg_write  <= w_v & w_reg_write;
      r_illegal    <= w_v & w_illegal;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_rs1_data   = r_rs1_data;
  assign o_rs2_data   = r_rs2_data;
  assign o_imm32      = r_imm32;
  assign o_rd         = r_rd;
  assign o_funct3     = r_funct3;
  assign o_funct7b5   = r_funct7b5;
  assign o_alu_op     = r_alu_op;
  assign o_alu_src    = r_alu_src;
  assign o_branch     = r_branch;
  assign o_jal        = r_jal;
  assign o_jalr       = r_jalr;
  assign o_lui        = r_lui;
  assign o_auipc      = r_auipc;
  assign o_mem_read   = r_mem_read;
  assign o_mem_write  = r_mem_write;
  assign o_mem_to_reg = r_mem_to_reg;
  assign o_reg_write  = r_reg_write;
  assign o_illegal    = r_illegal;

endmodule

// File: doc/idecode_stage.md
Name: idecode_stage

Overview:
- Decode stage of the mini RISC-V CPU; sits directly downstream of instruction fetch.
- Takes the 32-bit fetched instruction and holds the 32x32 integer register file.
- Generates sign-extended imm32 (byte offset, consumed by fetch for branches) and the control bundle.
- Registers all results into a decode/execute pipeline register with stall/flush control; register file written by writeback port.

Parameters:
- SP_INIT, 32'h0000_7FFC, reset value of x2 (sp).
- GP_INIT, 32'h0000_1800, reset value of x3 (gp).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- inst  in  32  instruction from fetch.
- inst_valid  in  1  inst holds a real instruction.
- stall  in  1  hold pipeline register contents.
- flush  in  1  replace next pipeline contents with bubble.
- wb_en  in  1  writeback enable.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- out_valid  out  1  pipeline register holds a valid instruction.
- rs1_data, rs2_data  out  32 each  source operand values.
- imm32  out  32  sign-extended immediate.
- rd  out  5  destination register index.
- funct3  out  3  inst[14:12].
- funct7b5  out  1  inst[30].
- alu_op  out  2  00 add, 01 branch compare, 10 R-type, 11 I-ALU.
- alu_src, branch, jal, jalr, lui, auipc, mem_read, mem_write, mem_to_reg, reg_write  out  1 each  control bundle.
- illegal  out  1  unrecognised opcode.

Behaviour:
- Reset (rst=0, async): all outputs 0; regs x0..x31 = 0 except x2=SP_INIT, x3=GP_INIT.
- Regfile write: posedge when wb_en=1 and wb_addr!=0; writes to x0 ignored, x0 always reads 0.
- Regfile read is combinational from inst[19:15] and inst[24:20].
- Write-through bypass: if wb_en=1, wb_addr!=0 and wb_addr equals the read index, the read returns wb_data in the same cycle.
- Latency: one cycle; decode of inst at edge N appears on outputs after edge N.
- Pipeline register update priority at posedge: flush > stall > load.
  - flush=1: out_valid=0, every control bit and illegal=0; data fields unspecified.
  - stall=1 (flush=0): hold all outputs; regfile writes still occur.
  - Else: load decoded values, out_valid=inst_valid; if inst_valid=0, all controls and illegal forced 0.
- Opcode decode (inst[6:0]):
  - 0110011 R: reg_write, alu_op=10.
  - 0010011 I-ALU: reg_write, alu_src, alu_op=11.
  - 0000011 LOAD: reg_write, alu_src, mem_read, mem_to_reg, alu_op=00.
  - 0100011 STORE: alu_src, mem_write, alu_op=00.
  - 1100011 BRANCH: branch, alu_op=01.
  - 1101111 JAL: jal, reg_write, alu_op=00.
  - 1100111 JALR: jalr, reg_write, alu_src, alu_op=00.
  - 0110111 LUI: lui, reg_write, alu_src.
  - 0010111 AUIPC: auipc, reg_write, alu_src.
  - Other: illegal=1, all other controls 0, out_valid follows inst_valid.
- Immediates, sign-extended from inst[31]:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - U: {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - R-type: imm32=0.
- rd=inst[11:7] always; reg_write=0 whenever rd=0.
- Reset asserted mid-operation clears everything immediately; no partial write completes.

Test Plan:
- Reset → x2=32'h7FFC, x3=32'h1800, out_valid=0; decode addi x5,x2,-4 (32'hFFC10293) → rs1_data=32'h7FFC, imm32=32'hFFFFFFFC, reg_write=1, alu_src=1, alu_op=11.
- Writeback bypass: wb_en=1, wb_addr=6, wb_data=32'hDEADBEEF with inst add x7,x6,x6 (32'h006303B3) in the same cycle → rs1_data=rs2_data=32'hDEADBEEF after the edge.
- Write to x0: wb_en=1, wb_addr=0, wb_data=5, then read x0 → 0.
- Branch beq x0,x0,-8 (32'hFE000CE3) → branch=1, alu_op=01, imm32=32'hFFFFFFF8, reg_write=0.
- Stall and flush both asserted → bubble (out_valid=0); stall alone for 3 cycles → outputs unchanged while a regfile write still lands.
- Opcode 7'b1111111 with inst_valid=1 → illegal=1, out_valid=1, mem_write=reg_write=0; rst pulsed low mid-cycle → outputs 0 immediately.
